// File: rtl/fixed_point_divider_if.sv
// Valid/ready operand and result channel of the Q5.3 fixed-point divider.
// The master drives operands and result acceptance; the slave is the divider.
interface fixed_point_divider_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] c;
    logic             ovf;
    logic             dz;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, c, ovf, dz
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, c, ovf, dz
    );
endinterface

// File: rtl/fixed_point_divider.sv
// Sequential unsigned Q(WIDTH-FRAC).FRAC divider: restoring division with one
// quotient bit per clock, saturating result, divide-by-zero flag.
module fixed_point_divider #(
    parameter int WIDTH = 8,
    parameter int FRAC  = 3
) (
    input logic                  clk,
    input logic                  rst_n,
    fixed_point_divider_if.slave bus
);
    localparam int QW    = WIDTH + FRAC;
    localparam int CNT_W = $clog2(QW);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(QW - 1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t           state, state_next;
    logic [QW-1:0]    dvd;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH:0]   rem;
    logic [QW-1:0]    quot;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] c_q;
    logic             ovf_q;
    logic             dz_q;

    logic [WIDTH:0]   rem_shift;
    logic [WIDTH+1:0] trial;
    logic             q_bit;
    logic [WIDTH:0]   rem_next;
    logic [QW-1:0]    quot_next;

    // Returns {ovf, c}: clamps any quotient that does not fit in WIDTH bits.
    function automatic logic [WIDTH:0] saturate(input logic [QW-1:0] q);
        if (|q[QW-1:WIDTH])
            return {1'b1, {WIDTH{1'b1}}};
        return {1'b0, q[WIDTH-1:0]};
    endfunction

    // A bit shifted out of the remainder MSB means the shifted value already
    // exceeds any divisor, so the subtraction is taken regardless of sign.
    always_comb begin
        rem_shift = {rem[WIDTH-1:0], dvd[QW-1]};
        trial     = {1'b0, rem_shift} - {2'b00, b_q};
        q_bit     = rem[WIDTH] | ~trial[WIDTH+1];
        rem_next  = q_bit ? trial[WIDTH:0] : rem_shift;
        quot_next = {quot[QW-2:0], q_bit};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (bus.in_valid) state_next = (bus.b == '0) ? DONE : CALC;
            CALC: if (cnt == LAST)  state_next = DONE;
            DONE: if (bus.out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dvd   <= '0;
            b_q   <= '0;
            rem   <= '0;
            quot  <= '0;
            cnt   <= '0;
            c_q   <= '0;
            ovf_q <= 1'b0;
            dz_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.in_valid) begin
                    dvd  <= {bus.a, {FRAC{1'b0}}};
                    b_q  <= bus.b;
                    rem  <= '0;
                    quot <= '0;
                    cnt  <= '0;
                    if (bus.b == '0) begin
                        c_q   <= '1;
                        ovf_q <= 1'b0;
                        dz_q  <= 1'b1;
                    end
                end
                CALC: begin
                    dvd  <= {dvd[QW-2:0], 1'b0};
                    rem  <= rem_next;
                    quot <= quot_next;
                    cnt  <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        {ovf_q, c_q} <= saturate(quot_next);
                        dz_q         <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.c         = c_q;
    assign bus.ovf       = ovf_q;
    assign bus.dz        = dz_q;
endmodule

// File: tb/tb_fixed_point_divider.sv
// Directed bench for fixed_point_divider: scoreboard of expected results
// filled at operand acceptance and drained when the divider presents output.
module tb_fixed_point_divider;
    logic clk = 1'b0;
    logic rst_n;

    fixed_point_divider_if #(.WIDTH(8)) bus ();

    fixed_point_divider #(.WIDTH(8), .FRAC(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] c;
        logic       ovf;
        logic       dz;
    } res_t;

    res_t sb[$];
    int   total = 0;
    int   bad   = 0;

    function automatic res_t model(input logic [7:0] av, input logic [7:0] bv);
        res_t r;
        int   q;
        if (bv == 8'h00) begin
            r.c = 8'hFF; r.ovf = 1'b0; r.dz = 1'b1;
        end else begin
            q = (int'(av) * 8) / int'(bv);
            if (q > 255) begin
                r.c = 8'hFF; r.ovf = 1'b1;
            end else begin
                r.c = q[7:0]; r.ovf = 1'b0;
            end
            r.dz = 1'b0;
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic send(input logic [7:0] av, input logic [7:0] bv);
        @(negedge clk);
        bus.a = av;
        bus.b = bv;
        bus.in_valid = 1'b1;
        chk("in_ready_idle", 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        sb.push_back(model(av, bv));
    endtask

    task automatic wait_result(input int exp_lat);
        int   lat;
        res_t e;
        lat = 0;
        while (bus.out_valid !== 1'b1 && lat < 40) begin
            chk("in_ready_busy", 32'(bus.in_ready), 32'd0);
            @(posedge clk);
            #1;
            lat++;
        end
        chk("latency", 32'(lat), 32'(exp_lat));
        if (sb.size() == 0) begin
            chk("sb_nonempty", 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            chk("c",   32'(bus.c),   32'(e.c));
            chk("ovf", 32'(bus.ovf), 32'(e.ovf));
            chk("dz",  32'(bus.dz),  32'(e.dz));
        end
    endtask

    task automatic consume(input logic with_in_valid);
        @(negedge clk);
        bus.out_ready = 1'b1;
        bus.in_valid  = with_in_valid;
        bus.a = 8'h77;
        bus.b = 8'h05;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b0;
        chk("out_valid_drop", 32'(bus.out_valid), 32'd0);
        chk("in_ready_back",  32'(bus.in_ready),  32'd1);
    endtask

    task automatic divide(input logic [7:0] av, input logic [7:0] bv);
        send(av, bv);
        wait_result((bv == 8'h00) ? 0 : 11);
        consume(1'b0);
    endtask

    initial begin
        logic [7:0] c_hold;
        logic [7:0] ra, rb;

        rst_n = 1'b0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        bus.a = '0;
        bus.b = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_c",         32'(bus.c),         32'd0);
        chk("rst_ovf",       32'(bus.ovf),       32'd0);
        chk("rst_dz",        32'(bus.dz),        32'd0);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_in_ready",  32'(bus.in_ready),  32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        divide(8'h10, 8'h08);
        divide(8'h0C, 8'h10);
        divide(8'h08, 8'h18);
        divide(8'hFF, 8'h01);
        divide(8'h20, 8'h00);
        divide(8'h01, 8'hFF);
        divide(8'hFF, 8'hFF);

        // Backpressure with operand pulses while the result is held.
        send(8'h30, 8'h08);
        wait_result(11);
        c_hold = bus.c;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            bus.in_valid = (i % 3 == 0);
            bus.a = 8'h55;
            bus.b = 8'h02;
            @(posedge clk);
            #1;
            chk("bp_c_stable", 32'(bus.c),         32'(c_hold));
            chk("bp_in_ready", 32'(bus.in_ready),  32'd0);
            chk("bp_valid",    32'(bus.out_valid), 32'd1);
        end
        bus.in_valid = 1'b0;
        // Result consumed while in_valid is high: operands must not be taken.
        consume(1'b1);
        divide(8'h40, 8'h10);

        // Asynchronous reset in the middle of CALC.
        send(8'hFF, 8'h03);
        repeat (5) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_c",         32'(bus.c),         32'd0);
        chk("arst_ovf",       32'(bus.ovf),       32'd0);
        chk("arst_dz",        32'(bus.dz),        32'd0);
        chk("arst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("arst_in_ready",  32'(bus.in_ready),  32'd1);
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        divide(8'h18, 8'h08);

        for (int i = 0; i < 6; i++) begin
            ra = 8'($urandom_range(0, 255));
            rb = (i == 3) ? 8'h00 : 8'($urandom_range(0, 255));
            divide(ra, rb);
        end

        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/fixed_point_divider.md
Name: fixed_point_divider

Overview:
Sequential unsigned fixed-point divider, the inverse operation of the PE's Q5.3 multiplier. It computes c = a / b on Q5.3 operands and returns a Q5.3 result. It uses an iterative restoring algorithm that produces one quotient bit per clock. It sits in the neuron PE datapath for normalisation/scaling and uses valid/ready handshakes on both its input and its output.

Parameters:
WIDTH, 8, total operand/result width (Q(WIDTH-FRAC).FRAC)
FRAC, 3, number of fraction bits in operands and result

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operands a, b are valid
in_ready  output  1  divider can accept operands (high only in IDLE)
a  input  WIDTH  dividend, Q5.3 unsigned
b  input  WIDTH  divisor, Q5.3 unsigned
out_valid  output  1  result c and flags are valid
out_ready  input  1  consumer accepts result
c  output  WIDTH  quotient, Q5.3 unsigned, saturated
ovf  output  1  quotient exceeded 2^WIDTH-1 and was saturated
dz  output  1  divisor was zero

Behaviour:
- Reset (asynchronous, rst_n low):
  - state=IDLE; c=0, ovf=0, dz=0, out_valid=0, in_ready=1.
  - All internal registers cleared.
  - A reset mid-CALC or mid-DONE aborts the operation; no result is emitted.
- Arithmetic:
  - Dividend D = {a, FRAC'b0}, which is WIDTH+FRAC = 11 bits.
  - Quotient Q = floor(D / b), 11 bits; truncation toward zero, no rounding.
  - If Q > 2^WIDTH-1: c = all ones, ovf=1. Otherwise c = Q[WIDTH-1:0], ovf=0.
- Algorithm: restoring division, MSB first, one quotient bit per CALC cycle, WIDTH+FRAC = 11 iterations.
  - Remainder register is WIDTH+1 bits.
  - Each iteration: shift the next D bit into the remainder, trial-subtract b, keep the result if non-negative, and set the quotient bit accordingly.
- FSM:
  - IDLE: in_ready=1. On in_valid at a clock edge, latch a and b. If b==0 go to DONE; else clear the iteration counter and go to CALC.
  - CALC: in_ready=0. Counter runs 0..10. At the edge where the counter==10, compute the final quotient bit, register c/ovf, and go to DONE.
  - DONE: out_valid=1 with c, ovf, dz held stable. On out_ready at a clock edge, drop out_valid and go to IDLE. With out_ready low, hold indefinitely.
- Divide by zero: one cycle after acceptance, enter DONE with c=all ones, dz=1, ovf=0. No CALC cycles are spent.
- Latency (b!=0), with handshake edge = edge 0:
  - CALC occupies edges 1..11.
  - out_valid is high after edge 11 (11 cycles of CALC).
  - Minimum initiation interval is 13 cycles (accept, 11 CALC, 1 DONE with out_ready=1).
- Handshake rules:
  - in_ready is low throughout CALC and DONE; in_valid is ignored there and no operands are latched.
  - out_valid is never asserted in IDLE or CALC.
  - c/ovf/dz may change only when entering DONE, or on reset.
  - There is no combinational path from in_valid/out_ready to any output; in_ready and out_valid are decoded from the state register.
- Simultaneous events: out_ready and in_valid high in the same DONE cycle means only the result is consumed. New operands are accepted at the earliest on the following edge, in IDLE.

Test Plan:
- a=0x10 (2.0), b=0x08 (1.0) -> c=0x10, ovf=0, dz=0; out_valid rises exactly 11 cycles after the accepting edge.
- a=0x0C (1.5), b=0x10 (2.0) -> c=0x06 (0.75). a=0x08 (1.0), b=0x18 (3.0) -> c=0x02 (0.25, truncated).
- a=0xFF (31.875), b=0x01 (0.125) -> Q=2040, so c=0xFF, ovf=1, dz=0.
- a=0x20, b=0x00 -> c=0xFF, dz=1, ovf=0; out_valid one cycle after acceptance.
- Backpressure: hold out_ready=0 for 20 cycles in DONE with in_valid pulsed -> c stable, in_ready=0, no new operands latched. Releasing out_ready gives a return to IDLE, and the next operands are accepted correctly.
- Assert rst_n low at CALC iteration 5 -> all outputs 0 and in_ready=1 immediately (asynchronous). A following division a=0x18, b=0x08 -> c=0x18.
